fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Instruction-memory read bus between the fetch stage (master) and the
//   instruction memory (slave).
//
//   rIMem_req   master -> slave   read request, held until acknowledged
//   rIMem_addr  master -> slave   read address, stable while rIMem_req high
//   wIMem_ack   slave  -> master  data returned this cycle
//   wIMem_data  slave  -> master  instruction word, valid with wIMem_ack
interface fetch_unit_if #(
   parameter int ADDR_W = 10,
   parameter int INSN_W = 16
);
   logic              rIMem_req;
   logic [ADDR_W-1:0] rIMem_addr;
   logic              wIMem_ack;
   logic [INSN_W-1:0] wIMem_data;

   modport master (
      output rIMem_req,
      output rIMem_addr,
      input  wIMem_ack,
      input  wIMem_data
   );

   modport slave (
      input  rIMem_req,
      input  rIMem_addr,
      output wIMem_ack,
      output wIMem_data
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage of the 8-bit accumulator CPU. Owns the fetch PC,
//   reads 16-bit instructions over a req/ack handshake and presents them to
//   the decoder through a 2-entry {pc, insn} buffer. A taken branch or jump
//   reported by the decoder on a pop flushes the buffer and redirects fetch.
//
//   Clock          in   rising-edge clock
//   Reset_n        in   asynchronous active-low reset
//   wStall         in   decoder cannot accept the presented instruction
//   wBranch_taken  in   conditional branch taken for the presented instruction
//   wJumpTaken     in   unconditional jump for the presented instruction
//   wBranch_dir    in   absolute redirect target
//   imem           if   instruction-memory read bus (master side)
//   rInstruction   out  buffer head instruction
//   rInstr_valid   out  buffer head is valid
//   rPC            out  address of buffer head
//
//   state         | meaning
//   --------------+--------------------------------------------------------
//   ST_IDLE       | one cycle after reset, no request
//   ST_FETCH      | request at fetch PC; push on ack
//   ST_WAIT_SPACE | buffer full, request low until a slot frees
//   ST_DISCARD    | redirect hit an unacknowledged request; hold it, drop its
//                 | data on ack, then fetch from the latched target
module fetch_unit #(
   parameter int ADDR_W = 10,
   parameter int INSN_W = 16,
   parameter int DEPTH  = 2
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              wStall,
   input  logic              wBranch_taken,
   input  logic              wJumpTaken,
   input  logic [ADDR_W-1:0] wBranch_dir,
   fetch_unit_if.master      imem,
   output logic [INSN_W-1:0] rInstruction,
   output logic              rInstr_valid,
   output logic [ADDR_W-1:0] rPC
);

   // The buffer is built for exactly two entries (1-bit pointers).
   localparam logic [1:0] DEPTH_C = 2'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_SPACE,
      ST_DISCARD
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic [1:0]        count_q, count_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] buf_pc_q   [2];
   logic [ADDR_W-1:0] buf_pc_d   [2];
   logic [INSN_W-1:0] buf_insn_q [2];
   logic [INSN_W-1:0] buf_insn_d [2];

   logic       req;
   logic       ack;
   logic       pop;
   logic       redirect;
   logic       push;
   logic [1:0] count_pop;
   logic [1:0] count_push;

   always_comb begin
      req        = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
      ack        = req && imem.wIMem_ack;
      pop        = (count_q != 2'd0) && !wStall;
      redirect   = pop && (wBranch_taken || wJumpTaken);
      count_pop  = count_q - {1'b0, pop};
      count_push = count_pop + 2'd1;

      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      target_d   = target_q;
      push       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (redirect) begin
               if (ack) begin
                  // Wrong-path data arriving on the redirect edge is dropped.
                  fetch_pc_d = wBranch_dir;
               end else begin
                  // Request must stay up with its old address until acked.
                  target_d = wBranch_dir;
                  state_d  = ST_DISCARD;
               end
            end else if (ack) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + ADDR_W'(1);
               if (count_push >= DEPTH_C) begin
                  state_d = ST_WAIT_SPACE;
               end
            end
         end
         ST_WAIT_SPACE: begin
            if (redirect) begin
               fetch_pc_d = wBranch_dir;
               state_d    = ST_FETCH;
            end else if (count_pop < DEPTH_C) begin
               // Leaving on the freeing pop keeps stall release gap-free.
               state_d = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            if (ack) begin
               fetch_pc_d = target_q;
               state_d    = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      buf_pc_d   = buf_pc_q;
      buf_insn_d = buf_insn_q;

      if (redirect) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         if (push) begin
            buf_pc_d[wr_ptr_q]   = fetch_pc_q;
            buf_insn_d[wr_ptr_q] = imem.wIMem_data;
            wr_ptr_d             = ~wr_ptr_q;
            count_d              = count_push;
         end else begin
            count_d = count_pop;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= '0;
         target_q   <= '0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         buf_pc_q   <= '{default: '0};
         buf_insn_q <= '{default: '0};
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         target_q   <= target_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         buf_pc_q   <= buf_pc_d;
         buf_insn_q <= buf_insn_d;
      end
   end

   assign imem.rIMem_req  = req;
   assign imem.rIMem_addr = fetch_pc_q;

   assign rInstr_valid = (count_q != 2'd0);
   assign rInstruction = buf_insn_q[rd_ptr_q];
   assign rPC          = buf_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   localparam int ADDR_W = 10;
   localparam int INSN_W = 16;

   logic              Clock;
   logic              Reset_n;
   logic              wStall;
   logic              wBranch_taken;
   logic              wJumpTaken;
   logic [ADDR_W-1:0] wBranch_dir;
   logic [INSN_W-1:0] rInstruction;
   logic              rInstr_valid;
   logic [ADDR_W-1:0] rPC;

   fetch_unit_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) imem ();

   fetch_unit #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .DEPTH(2)) dut (
      .Clock         (Clock),
      .Reset_n       (Reset_n),
      .wStall        (wStall),
      .wBranch_taken (wBranch_taken),
      .wJumpTaken    (wJumpTaken),
      .wBranch_dir   (wBranch_dir),
      .imem          (imem),
      .rInstruction  (rInstruction),
      .rInstr_valid  (rInstr_valid),
      .rPC           (rPC)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Instruction memory model: word is a fixed function of its address,
   // ack once the request has been pending for at least lat cycles.
   function automatic logic [INSN_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return {a[5:0] ^ 6'h2B, a};
   endfunction

   int unsigned lat;
   int unsigned age;

   assign imem.wIMem_ack  = imem.rIMem_req && (age >= lat);
   assign imem.wIMem_data = mem_word(imem.rIMem_addr);

   always @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)                                 age <= 0;
      else if (imem.rIMem_req && !imem.wIMem_ack)   age <= age + 1;
      else                                          age <= 0;
   end

   // Reference model: program-order PC of the instruction the decoder should
   // see next. Each pop pushes its expectation; the monitor pops and compares.
   logic [ADDR_W-1:0] exp_q [$];
   logic [ADDR_W-1:0] cur_pc;
   logic [ADDR_W-1:0] sb_e;
   logic              p_req, p_ack;
   logic [ADDR_W-1:0] p_addr;

   always @(negedge Clock) begin
      if (!Reset_n) begin
         p_req = 1'b0;
         p_ack = 1'b0;
      end else begin
         if (rInstr_valid && !wStall) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard: unexpected pop of rPC 0x%0h, nothing expected", rPC);
            end else begin
               sb_e = exp_q.pop_front();
               check("pop_pc", 32'(rPC), 32'(sb_e));
               check("pop_insn", 32'(rInstruction), 32'(mem_word(sb_e)));
            end
         end
         if (p_req && !p_ack) begin
            check("req_held", 32'(imem.rIMem_req), 1);
            check("addr_held", 32'(imem.rIMem_addr), 32'(p_addr));
         end
         p_req  = imem.rIMem_req;
         p_ack  = imem.wIMem_ack;
         p_addr = imem.rIMem_addr;
      end
   end

   // Drive one cycle of decoder inputs, update the model on a pop, advance.
   task automatic step(input logic stall, input logic jmp, input logic br, input logic [ADDR_W-1:0] dir);
      wStall        = stall;
      wJumpTaken    = jmp;
      wBranch_taken = br;
      wBranch_dir   = dir;
      if (rInstr_valid && !stall) begin
         exp_q.push_back(cur_pc);
         cur_pc = (jmp || br) ? dir : cur_pc + 10'd1;
      end
      @(posedge Clock);
      #1;
   endtask

   // Asserts reset mid-cycle, checks asynchronous clearing, releases it and
   // returns in cycle 1 after release.
   task automatic do_reset(input int unsigned new_lat);
      #2 Reset_n = 1'b0;
      #1;
      check("rst_req", 32'(imem.rIMem_req), 0);
      check("rst_addr", 32'(imem.rIMem_addr), 0);
      check("rst_valid", 32'(rInstr_valid), 0);
      check("rst_insn", 32'(rInstruction), 0);
      check("rst_pc", 32'(rPC), 0);
      lat           = new_lat;
      wStall        = 1'b0;
      wJumpTaken    = 1'b0;
      wBranch_taken = 1'b0;
      exp_q.delete();
      cur_pc = '0;
      @(posedge Clock);
      #1;
      Reset_n = 1'b1;
      check("idle_req", 32'(imem.rIMem_req), 0);
      step(1'b0, 1'b0, 1'b0, '0);
      check("first_req", 32'(imem.rIMem_req), 1);
      check("first_addr", 32'(imem.rIMem_addr), 0);
      check("cycle1_valid", 32'(rInstr_valid), 0);
   endtask

   task automatic redirect_check(input logic jmp, input logic br, input logic [ADDR_W-1:0] tgt);
      check("redir_pre_valid", 32'(rInstr_valid), 1);
      step(1'b0, jmp, br, tgt);
      check("bubble_valid", 32'(rInstr_valid), 0);
      check("redir_req", 32'(imem.rIMem_req), 1);
      check("redir_addr", 32'(imem.rIMem_addr), 32'(tgt));
      step(1'b0, 1'b0, 1'b0, '0);
      check("redir_valid", 32'(rInstr_valid), 1);
      check("redir_pc", 32'(rPC), 32'(tgt));
   endtask

   task automatic run_to(input logic [ADDR_W-1:0] pc, input int budget);
      for (int i = 0; i < budget && !(rInstr_valid && cur_pc == pc); i++) begin
         step(1'b0, 1'b0, 1'b0, '0);
      end
      check("run_to_reached", 32'(rInstr_valid && (cur_pc == pc)), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [ADDR_W-1:0] wrap_exp [4];
   int                held;
   logic              r_stall, r_redir, r_jmp;

   initial begin
      Reset_n       = 1'b1;
      wStall        = 1'b0;
      wJumpTaken    = 1'b0;
      wBranch_taken = 1'b0;
      wBranch_dir   = '0;
      lat           = 0;
      cur_pc        = '0;
      wrap_exp      = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      #1 Reset_n = 1'b0;
      @(posedge Clock);
      #1;

      // Reset, then zero-wait streaming from address 0.
      do_reset(0);
      step(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         check("stream_valid", 32'(rInstr_valid), 1);
         step(1'b0, 1'b0, 1'b0, '0);
      end
      check("stall_start_pc", 32'(rPC), 3);

      // Stall at rPC 3; a jump flag during the stall must be ignored.
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            check("stall_req_low", 32'(imem.rIMem_req), 0);
            check("stall_valid", 32'(rInstr_valid), 1);
            check("stall_pc", 32'(rPC), 3);
            check("stall_insn", 32'(rInstruction), 32'(mem_word(10'd3)));
         end
         step(1'b1, (i == 2), 1'b0, 10'h155);
      end
      for (int i = 0; i < 2; i++) begin
         check("release_valid", 32'(rInstr_valid), 1);
         step(1'b0, 1'b0, 1'b0, '0);
      end

      // Jump on pop of rPC 5, then branch to 0x07F.
      check("jump_src_pc", 32'(rPC), 5);
      redirect_check(1'b1, 1'b0, 10'h200);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      redirect_check(1'b0, 1'b1, 10'h07F);

      // Slow memory: redirect while the request for 0x009 is pending.
      lat = 3;
      step(1'b0, 1'b1, 1'b0, 10'h008);
      run_to(10'h008, 40);
      check("slow_req", 32'(imem.rIMem_req), 1);
      check("slow_addr", 32'(imem.rIMem_addr), 32'h009);
      step(1'b0, 1'b1, 1'b0, 10'h100);
      held = 0;
      for (int i = 0; i < 10 && imem.rIMem_addr == 10'h009; i++) begin
         check("discard_no_valid", 32'(rInstr_valid), 0);
         held++;
         step(1'b0, 1'b0, 1'b0, '0);
      end
      check("discard_hold_cycles", 32'(held), 3);
      check("slow_target_req", 32'(imem.rIMem_req), 1);
      check("slow_target_addr", 32'(imem.rIMem_addr), 32'h100);
      run_to(10'h100, 20);
      check("slow_target_pc", 32'(rPC), 32'h100);

      // Wrap of the fetch PC through 0x3FF.
      lat = 0;
      step(1'b0, 1'b0, 1'b1, 10'h3FE);
      step(1'b0, 1'b0, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
         check("wrap_valid", 32'(rInstr_valid), 1);
         check("wrap_pc", 32'(rPC), 32'(wrap_exp[k]));
         step(1'b0, 1'b0, 1'b0, '0);
      end

      // Reset while a slow request is outstanding.
      lat = 3;
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      check("pre_reset_req", 32'(imem.rIMem_req), 1);
      do_reset(0);
      step(1'b0, 1'b0, 1'b0, '0);
      check("post_reset_valid", 32'(rInstr_valid), 1);
      check("post_reset_pc", 32'(rPC), 0);

      // Randomized stalls, redirects and memory latency.
      for (int i = 0; i < 800; i++) begin
         r_stall = ($urandom_range(0, 2) == 0);
         r_redir = ($urandom_range(0, 7) == 0);
         r_jmp   = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
         step(r_stall, r_redir & r_jmp, r_redir & ~r_jmp, 10'($urandom));
      end
      step(1'b1, 1'b0, 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
